sd_cmd_seq: RTL and testbench

- Hardware command sequencer that sits directly upstream of the sd SPI byte engine and drives its register port in place of MCU byte-by-byte access.
- On one start pulse, it sends a 7-byte SD command frame: one 0xFF lead-in, then 6 frame bytes.
- It then polls with 0xFF bytes until an R1 response (bit7 = 0) arrives or a poll limit expires.
- The result is returned in one byte plus flags, so firmware issues CMD0/CMD8/CMD17-style commands with a single write.

---
 rtl/sd_cmd_seq.sv | 199 +++++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_seq
// Purpose  : Sends a 7-byte SD command frame through the sd SPI byte engine's
//            register port, then polls with 0xFF until an R1 byte (bit7 = 0)
//            arrives or MAX_POLL poll bytes have been sent.
// Revision : 1.0  initial release
// ============================================================================
module sd_cmd_seq #(
  parameter int unsigned MAX_POLL = 8,   // 1..255 poll bytes before timeout
  parameter int unsigned SETTLE   = 4    // 2..15 cycles after a write before status read
) (
  input  logic        clk_i,
  input  logic        mcu_rst_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_i,
  input  logic [31:0] arg_i,
  input  logic [6:0]  crc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  resp_o,
  output logic        timeout_o,
  output logic        sd_wr_o,
  output logic        sd_rd_o,
  output logic [7:0]  sd_addr_o8,
  output logic [7:0]  sd_wrdat_o8,
  input  logic [7:0]  sd_rddat_i8
);

  localparam logic [7:0] MAX_POLL_B = 8'(MAX_POLL);
  localparam logic [3:0] SETTLE_B   = 4'(SETTLE);
  localparam logic [7:0] ADDR_DATA  = 8'h00;
  localparam logic [7:0] ADDR_STAT  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR       = 4'd1,
    S_SETTLE   = 4'd2,
    S_STAT_RD  = 4'd3,
    S_STAT_CHK = 4'd4,
    S_NEXT     = 4'd5,
    S_DAT_RD   = 4'd6,
    S_DAT_CHK  = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  poll_q, poll_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        poll_ph_q, poll_ph_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wrdat_q, wrdat_d;
  logic [7:0]  frame_byte;
  logic [7:0]  poll_inc;

  // Frame byte selected by the current index, built from the latched request.
  always_comb begin
    frame_byte = 8'hFF;
    case (idx_q)
      3'd0:    frame_byte = 8'hFF;
      3'd1:    frame_byte = {2'b01, cmd_q};
      3'd2:    frame_byte = arg_q[31:24];
      3'd3:    frame_byte = arg_q[23:16];
      3'd4:    frame_byte = arg_q[15:8];
      3'd5:    frame_byte = arg_q[7:0];
      3'd6:    frame_byte = {crc_q, 1'b1};
      default: frame_byte = 8'hFF;
    endcase
  end

  assign poll_inc = poll_q + 8'd1;

  // Next-state and sd-port strobes; addr/data hold their last value between accesses.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    cnt_d       = cnt_q;
    poll_ph_d   = poll_ph_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    crc_d       = crc_q;
    resp_d      = resp_q;
    timeout_d   = timeout_q;
    sd_wr_o     = 1'b0;
    sd_rd_o     = 1'b0;
    sd_addr_o8  = addr_q;
    sd_wrdat_o8 = wrdat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cmd_d     = cmd_i;
          arg_d     = arg_i;
          crc_d     = crc_i;
          timeout_d = 1'b0;
          idx_d     = 3'd0;
          poll_d    = 8'd0;
          poll_ph_d = 1'b0;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        sd_wr_o     = 1'b1;
        sd_addr_o8  = ADDR_DATA;
        sd_wrdat_o8 = poll_ph_q ? 8'hFF : frame_byte;
        cnt_d       = SETTLE_B;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_STAT_RD;
      end
      S_STAT_RD: begin
        sd_rd_o    = 1'b1;
        sd_addr_o8 = ADDR_STAT;
        state_d    = S_STAT_CHK;
      end
      S_STAT_CHK: begin
        // The engine can stay busy arbitrarily long; keep polling status.
        if (sd_rddat_i8[0])  state_d = S_STAT_RD;
        else if (poll_ph_q)  state_d = S_DAT_RD;
        else                 state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q < 3'd6) idx_d = idx_q + 3'd1;
        else              poll_ph_d = 1'b1;
        state_d = S_WR;
      end
      S_DAT_RD: begin
        sd_rd_o    = 1'b1;
        sd_addr_o8 = ADDR_DATA;
        state_d    = S_DAT_CHK;
      end
      S_DAT_CHK: begin
        if (!sd_rddat_i8[7]) begin
          resp_d  = sd_rddat_i8;
          state_d = S_DONE;
        end else begin
          poll_d = poll_inc;
          if (poll_inc == MAX_POLL_B) begin
            resp_d    = 8'hFF;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    addr_d  = sd_addr_o8;
    wrdat_d = sd_wrdat_o8;
  end

  // State and datapath registers; reset drops the strobes immediately.
  always_ff @(posedge clk_i or posedge mcu_rst_i) begin
    if (mcu_rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      poll_q    <= 8'd0;
      cnt_q     <= 4'd0;
      poll_ph_q <= 1'b0;
      cmd_q     <= 6'd0;
      arg_q     <= 32'd0;
      crc_q     <= 7'd0;
      resp_q    <= 8'hFF;
      timeout_q <= 1'b0;
      addr_q    <= 8'd0;
      wrdat_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      cnt_q     <= cnt_d;
      poll_ph_q <= poll_ph_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      wrdat_q   <= wrdat_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign resp_o    = resp_q;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_seq
// Purpose  : Scoreboard bench for sd_cmd_seq with a reactive sd engine model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  cmd_i = '0;
  logic [31:0] arg_i = '0;
  logic [6:0]  crc_i = '0;
  logic        busy_o, done_o, timeout_o, sd_wr_o, sd_rd_o;
  logic [7:0]  resp_o, sd_addr_o8, sd_wrdat_o8;
  logic [7:0]  sd_rddat_i8 = 8'h00;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: expected write bytes and expected {resp, timeout} per done.
  logic [7:0] exp_wr_q[$];
  logic [8:0] exp_done_q[$];

  // sd engine model state
  int         wr_cnt = 0;
  int         resp_at = -1;
  logic [7:0] resp_byte = 8'h01;
  logic [7:0] rx_byte = 8'hFF;
  int         sd_busy_cnt = 0;
  int         force_cnt = 0;
  bit         stretch_en = 1'b0;
  int         forced_stat_rds = 0;
  int         done_cnt = 0;
  bit         prev_done = 1'b0;

  sd_cmd_seq #(.MAX_POLL(8), .SETTLE(4)) dut (
    .clk_i       (clk),
    .mcu_rst_i   (rst),
    .start_i     (start_i),
    .cmd_i       (cmd_i),
    .arg_i       (arg_i),
    .crc_i       (crc_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .resp_o      (resp_o),
    .timeout_o   (timeout_o),
    .sd_wr_o     (sd_wr_o),
    .sd_rd_o     (sd_rd_o),
    .sd_addr_o8  (sd_addr_o8),
    .sd_wrdat_o8 (sd_wrdat_o8),
    .sd_rddat_i8 (sd_rddat_i8)
  );

  always #8 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / sd model: reacts to DUT strobes on the falling edge.
  always @(negedge clk) begin
    if (sd_busy_cnt > 0) sd_busy_cnt--;
    if (force_cnt > 0) force_cnt--;
    if (sd_wr_o) begin
      chk("wr_during_busy", force_cnt, 0);
      chk("wr_addr", sd_addr_o8, 8'h00);
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_wr", sd_wrdat_o8, 32'h100);
      end else begin
        chk("wr_data", sd_wrdat_o8, exp_wr_q.pop_front());
      end
      rx_byte = (wr_cnt == resp_at) ? resp_byte : 8'hFF;
      wr_cnt++;
      sd_busy_cnt = 6;
      if (stretch_en && wr_cnt == 4) force_cnt = 20;
    end
    if (sd_rd_o) begin
      if (sd_addr_o8 == 8'h02) begin
        sd_rddat_i8 = {7'b0, (sd_busy_cnt > 0) || (force_cnt > 0)};
        if (force_cnt > 0) forced_stat_rds++;
      end else begin
        chk("dat_rd_addr", sd_addr_o8, 8'h00);
        sd_rddat_i8 = rx_byte;
      end
    end
    if (prev_done) begin
      chk("done_width", done_o, 1'b0);
    end
    prev_done = done_o;
    if (done_o) begin
      done_cnt++;
      chk("done_busy", busy_o, 1'b0);
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", {resp_o, timeout_o}, 32'h200);
      end else begin
        chk("resp_timeout", {resp_o, timeout_o}, exp_done_q.pop_front());
      end
    end
  end

  task automatic push7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, input int npoll);
    exp_wr_q.push_back(b0); exp_wr_q.push_back(b1); exp_wr_q.push_back(b2);
    exp_wr_q.push_back(b3); exp_wr_q.push_back(b4); exp_wr_q.push_back(b5);
    exp_wr_q.push_back(b6);
    for (int i = 0; i < npoll; i++) exp_wr_q.push_back(8'hFF);
  endtask

  task automatic pulse_start(input logic [5:0] c, input logic [31:0] a, input logic [6:0] r);
    @(negedge clk);
    cmd_i = c; arg_i = a; crc_i = r; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", done_cnt >= target, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_resp", resp_o, 8'hFF);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_strobes", {sd_wr_o, sd_rd_o}, 2'b00);
    chk("rst_addr_dat", {sd_addr_o8, sd_wrdat_o8}, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CMD0: R1 = 0x01 on the second poll byte
    wr_cnt = 0; resp_at = 8; resp_byte = 8'h01;
    push7(8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 2);
    exp_done_q.push_back({8'h01, 1'b0});
    pulse_start(6'd0, 32'h0000_0000, 7'h4A);
    chk("busy_after_start", busy_o, 1'b1);
    wait_done(1);
    chk("cmd0_wr_count", wr_cnt, 9);
    chk("cmd0_queue_empty", exp_wr_q.size(), 0);

    // Timeout: never responds, 7 frame + 8 poll writes
    wr_cnt = 0; resp_at = -1;
    push7(8'hFF, 8'h51, 8'h00, 8'h00, 8'h10, 8'h00, 8'h55, 8);
    exp_done_q.push_back({8'hFF, 1'b1});
    pulse_start(6'd17, 32'h0000_1000, 7'h2A);
    wait_done(2);
    chk("timeout_wr_count", wr_cnt, 15);
    repeat (5) @(negedge clk);
    chk("timeout_held", timeout_o, 1'b1);

    // Busy stretch after idx3 write, plus arg change after start
    wr_cnt = 0; resp_at = 7; resp_byte = 8'h01; stretch_en = 1'b1; forced_stat_rds = 0;
    push7(8'hFF, 8'h48, 8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 1);
    exp_done_q.push_back({8'h01, 1'b0});
    pulse_start(6'd8, 32'h1234_5678, 7'h43);
    arg_i = 32'h0;
    chk("timeout_cleared", timeout_o, 1'b0);
    wait_done(3);
    stretch_en = 1'b0;
    chk("stretch_stat_reads", forced_stat_rds >= 2, 1'b1);
    chk("stretch_wr_count", wr_cnt, 8);

    // Start while busy: second pulse mid-frame must be ignored
    wr_cnt = 0; resp_at = 9; resp_byte = 8'h00;
    push7(8'hFF, 8'h77, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23, 3);
    exp_done_q.push_back({8'h00, 1'b0});
    pulse_start(6'h37, 32'hDEAD_BEEF, 7'h11);
    for (int i = 0; i < 2000 && wr_cnt < 3; i++) @(negedge clk);
    pulse_start(6'h01, 32'h0000_0000, 7'h00);
    wait_done(4);
    repeat (20) @(negedge clk);
    chk("single_done", done_cnt, 4);
    chk("busy_test_wr_count", wr_cnt, 10);

    // Reset during the idx4 write
    wr_cnt = 0; resp_at = -1;
    push7(8'hFF, 8'h51, 8'h00, 8'h00, 8'h10, 8'h00, 8'h55, 8);
    exp_done_q.push_back({8'hFF, 1'b1});
    pulse_start(6'd17, 32'h0000_1000, 7'h2A);
    begin
      int cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!(sd_wr_o && wr_cnt == 4) && cyc < 2000);
      chk("reached_idx4", cyc < 2000, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_strobes", {sd_wr_o, sd_rd_o}, 2'b00);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_resp", resp_o, 8'hFF);
    exp_wr_q.delete();
    exp_done_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done_on_rst", done_cnt, 4);

    // Full sequence after reset
    wr_cnt = 0; resp_at = 8; resp_byte = 8'h01;
    push7(8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 2);
    exp_done_q.push_back({8'h01, 1'b0});
    pulse_start(6'd0, 32'h0000_0000, 7'h4A);
    wait_done(5);
    chk("post_rst_wr_count", wr_cnt, 9);
    chk("final_queues", exp_wr_q.size() + exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
